// File: rtl/store_sequencer_if.sv
// Store request / data-memory bundle used between the control unit, the store
// sequencer and the data memory port.
interface store_sequencer_if;
   logic        start;
   logic [31:0] addr;
   logic [31:0] data_b;
   logic [1:0]  ct;
   logic        busy;
   logic        done;
   logic        err;
   logic [31:0] mem_addr;
   logic        mem_wr;
   logic [31:0] mem_wr_data;
   logic [31:0] mem_rd_data;

   modport slave (
      input  start, addr, data_b, ct, mem_rd_data,
      output busy, done, err, mem_addr, mem_wr, mem_wr_data
   );

   modport master (
      output start, addr, data_b, ct, mem_rd_data,
      input  busy, done, err, mem_addr, mem_wr, mem_wr_data
   );
endinterface

// File: rtl/store_sequencer.sv
// Runs one sw/sh/sb as a read-modify-write on the data memory port:
// word stores write directly, halfword/byte stores read, merge the low lane, then write.
module store_sequencer #(
   parameter int RD_LAT = 1
) (
   input  logic             clk,
   input  logic             reset,
   store_sequencer_if.slave bus
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_READ  = 3'd1,
      S_WRITE = 3'd2,
      S_DONE  = 3'd3,
      S_ERR   = 3'd4
   } state_t;

   state_t      r_state;
   state_t      w_next;
   logic [31:0] r_data_b;
   logic [1:0]  r_ct;
   logic [31:0] r_mr;
   logic [2:0]  r_rd_cnt;
   logic [31:0] r_mem_addr;
   logic [31:0] r_last_wr_data;
   logic        r_busy;
   logic        r_done;
   logic        r_err;
   logic        r_mem_wr;

   logic        w_accept;
   logic        w_reject;
   logic        w_rd_last;
   logic [31:0] w_merged;

   // New low-order lane from B replaces the word read; upper bytes are kept.
   function automatic logic [31:0] merge_store(input logic [1:0]  ct,
                                               input logic [31:0] old_word,
                                               input logic [31:0] b);
      logic [31:0] res;
      case (ct)
         2'd1:    res = {old_word[31:16], b[15:0]};
         2'd2:    res = {old_word[31:8],  b[7:0]};
         default: res = b;
      endcase
      return res;
   endfunction

   // Request decode: acceptance, rejection and end of the read wait.
   always_comb begin
      w_reject = 1'b0;
      case (bus.ct)
         2'd0:    w_reject = (bus.addr[1:0] != 2'b00);
         2'd1:    w_reject = bus.addr[0];
         2'd2:    w_reject = 1'b0;
         default: w_reject = 1'b1;
      endcase
      w_accept  = (r_state == S_IDLE) && bus.start;
      w_rd_last = (r_state == S_READ) && (r_rd_cnt == 3'(RD_LAT - 1));
      w_merged  = merge_store(r_ct, r_mr, r_data_b);
   end

   // Next-state logic.
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (bus.start) begin
               if (w_reject) begin
                  w_next = S_ERR;
               end else if (bus.ct == 2'd0) begin
                  w_next = S_WRITE;
               end else begin
                  w_next = S_READ;
               end
            end else begin
               w_next = S_IDLE;
            end
         end
         S_READ: begin
            if (w_rd_last) begin
               w_next = S_WRITE;
            end else begin
               w_next = S_READ;
            end
         end
         S_WRITE: w_next = S_DONE;
         S_DONE:  w_next = S_IDLE;
         S_ERR:   w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // State, capture registers and registered outputs (decoded from next state).
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state        <= S_IDLE;
         r_data_b       <= 32'd0;
         r_ct           <= 2'd0;
         r_mr           <= 32'd0;
         r_rd_cnt       <= 3'd0;
         r_mem_addr     <= 32'd0;
         r_last_wr_data <= 32'd0;
         r_busy         <= 1'b0;
         r_done         <= 1'b0;
         r_err          <= 1'b0;
         r_mem_wr       <= 1'b0;
      end else begin
         r_state  <= w_next;
         r_busy   <= (w_next != S_IDLE);
         r_done   <= (w_next == S_DONE) || (w_next == S_ERR);
         r_err    <= (w_next == S_ERR);
         r_mem_wr <= (w_next == S_WRITE);
         if (w_accept) begin
            r_mem_addr <= bus.addr;
            r_data_b   <= bus.data_b;
            r_ct       <= bus.ct;
            r_rd_cnt   <= 3'd0;
         end else if (r_state == S_READ) begin
            r_rd_cnt <= r_rd_cnt + 3'd1;
         end
         if (w_rd_last) begin
            r_mr <= bus.mem_rd_data;
         end
         if (r_state == S_WRITE) begin
            r_last_wr_data <= w_merged;
         end
      end
   end

   // Write data is the merge while writing, otherwise the last value written.
   always_comb begin
      bus.mem_wr_data = r_last_wr_data;
      if (r_state == S_WRITE) begin
         bus.mem_wr_data = w_merged;
      end else begin
         bus.mem_wr_data = r_last_wr_data;
      end
   end

   assign bus.busy     = r_busy;
   assign bus.done     = r_done;
   assign bus.err      = r_err;
   assign bus.mem_wr   = r_mem_wr;
   assign bus.mem_addr = r_mem_addr;

endmodule

// File: tb/tb_store_sequencer.sv
// Directed bench for store_sequencer: one DUT with RD_LAT=1, one with RD_LAT=3,
// each attached to a small word memory model.
module tb_store_sequencer;

   logic clk;
   logic reset;
   int   n_tests;
   int   n_fail;

   store_sequencer_if if1();
   store_sequencer_if if3();

   store_sequencer #(.RD_LAT(1)) u_dut1 (.clk(clk), .reset(reset), .bus(if1.slave));
   store_sequencer #(.RD_LAT(3)) u_dut3 (.clk(clk), .reset(reset), .bus(if3.slave));

   logic [31:0] mem1 [0:15];
   logic [31:0] mem3 [0:15];
   logic        pl1_en, pl3_en;
   logic [3:0]  pl1_idx, pl3_idx;
   logic [31:0] pl1_val, pl3_val;
   int          age3;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory models; the RD_LAT=3 one returns junk until the third read cycle.
   always @(posedge clk) begin
      if (pl1_en) mem1[pl1_idx] <= pl1_val;
      else if (if1.mem_wr) mem1[if1.mem_addr[5:2]] <= if1.mem_wr_data;
      if (pl3_en) mem3[pl3_idx] <= pl3_val;
      else if (if3.mem_wr) mem3[if3.mem_addr[5:2]] <= if3.mem_wr_data;
      age3 <= (if3.busy && !if3.mem_wr && !if3.done) ? age3 + 1 : 0;
   end
   assign if1.mem_rd_data = mem1[if1.mem_addr[5:2]];
   assign if3.mem_rd_data = (age3 >= 2) ? mem3[if3.mem_addr[5:2]] : 32'hDEAD_BEEF;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic preload1(input logic [3:0] idx, input logic [31:0] val);
      pl1_idx = idx; pl1_val = val; pl1_en = 1'b1;
      tick();
      pl1_en = 1'b0;
   endtask

   // Issues one request on the RD_LAT=1 DUT and records what it does for 10 cycles.
   task automatic obs1(input logic [31:0] a, input logic [31:0] b, input logic [1:0] ct,
                       output int wr_cyc, output logic [31:0] wr_data, output logic [31:0] wr_addr,
                       output int done_cyc, output logic err_seen, output int nwr, output int nrd);
      wr_cyc = -1; done_cyc = -1; nwr = 0; nrd = 0; err_seen = 1'b0;
      wr_data = 32'd0; wr_addr = 32'd0;
      if1.addr = a; if1.data_b = b; if1.ct = ct; if1.start = 1'b1;
      for (int c = 1; c <= 10; c++) begin
         tick();
         if (c == 1) begin
            if1.start = 1'b0; if1.addr = 32'hFFFF_FFFF; if1.data_b = 32'h0; if1.ct = 2'd3;
         end
         if (if1.mem_wr) begin
            nwr++; wr_cyc = c; wr_data = if1.mem_wr_data; wr_addr = if1.mem_addr;
         end else if (if1.busy && !if1.done) begin
            nrd++;
         end
         if (if1.done && done_cyc < 0) begin
            done_cyc = c; err_seen = if1.err;
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b0;
      if1.start = 1'b0; if1.addr = 32'h0; if1.data_b = 32'h0; if1.ct = 2'd0;
      if3.start = 1'b0; if3.addr = 32'h0; if3.data_b = 32'h0; if3.ct = 2'd0;
      pl1_en = 1'b0; pl3_en = 1'b0; pl1_idx = 4'd0; pl3_idx = 4'd0; pl1_val = 32'd0; pl3_val = 32'd0;
      repeat (3) tick();
      n_tests++; if (if1.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", if1.busy); end
      n_tests++; if (if1.done !== 1'b0 || if1.err !== 1'b0) begin n_fail++; $display("FAIL reset_done_err: got %b%b want 00", if1.done, if1.err); end
      n_tests++; if (if1.mem_wr !== 1'b0) begin n_fail++; $display("FAIL reset_mem_wr: got %b want 0", if1.mem_wr); end
      n_tests++; if (if1.mem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_mem_addr: got %h want 0", if1.mem_addr); end
      n_tests++; if (if1.mem_wr_data !== 32'h0) begin n_fail++; $display("FAIL reset_mem_wr_data: got %h want 0", if1.mem_wr_data); end
      n_tests++; if (if3.busy !== 1'b0 || if3.mem_wr !== 1'b0) begin n_fail++; $display("FAIL reset_lat3: busy %b mem_wr %b want 0 0", if3.busy, if3.mem_wr); end
      reset = 1'b1;
      tick();
   endtask

   task automatic test_word();
      int wc, dc, nw, nr; logic [31:0] wd, wa; logic e;
      preload1(4'd4, 32'hAAAA_AAAA);
      obs1(32'h10, 32'h0000_0008, 2'd0, wc, wd, wa, dc, e, nw, nr);
      n_tests++; if (wc !== 1) begin n_fail++; $display("FAIL word_wr_cycle: got %0d want 1", wc); end
      n_tests++; if (wd !== 32'h0000_0008) begin n_fail++; $display("FAIL word_wr_data: got %h want 00000008", wd); end
      n_tests++; if (wa !== 32'h10) begin n_fail++; $display("FAIL word_wr_addr: got %h want 00000010", wa); end
      n_tests++; if (nr !== 0 || nw !== 1) begin n_fail++; $display("FAIL word_cycles: reads %0d writes %0d want 0 1", nr, nw); end
      n_tests++; if (dc !== 2 || e !== 1'b0) begin n_fail++; $display("FAIL word_done: cycle %0d err %b want 2 0", dc, e); end
      n_tests++; if (mem1[4] !== 32'h0000_0008) begin n_fail++; $display("FAIL word_mem: got %h want 00000008", mem1[4]); end
      n_tests++; if (if1.done !== 1'b0 || if1.busy !== 1'b0) begin n_fail++; $display("FAIL word_idle_after: done %b busy %b want 0 0", if1.done, if1.busy); end
      n_tests++; if (if1.mem_wr_data !== 32'h0000_0008) begin n_fail++; $display("FAIL word_hold_data: got %h want 00000008", if1.mem_wr_data); end
   endtask

   task automatic test_halfword();
      int wc, dc, nw, nr; logic [31:0] wd, wa; logic e;
      preload1(4'd8, 32'hFFFF_FFFF);
      obs1(32'h20, 32'h0000_0008, 2'd1, wc, wd, wa, dc, e, nw, nr);
      n_tests++; if (nr !== 1) begin n_fail++; $display("FAIL half_reads: got %0d want 1", nr); end
      n_tests++; if (wc !== 2 || wd !== 32'hFFFF_0008) begin n_fail++; $display("FAIL half_write: cycle %0d data %h want 2 ffff0008", wc, wd); end
      n_tests++; if (dc !== 3 || e !== 1'b0) begin n_fail++; $display("FAIL half_done: cycle %0d err %b want 3 0", dc, e); end
      n_tests++; if (mem1[8] !== 32'hFFFF_0008) begin n_fail++; $display("FAIL half_mem: got %h want ffff0008", mem1[8]); end
   endtask

   task automatic test_byte();
      int wc, dc, nw, nr; logic [31:0] wd, wa; logic e;
      preload1(4'd12, 32'hFFFF_FFFF);
      obs1(32'h30, 32'h1234_5608, 2'd2, wc, wd, wa, dc, e, nw, nr);
      n_tests++; if (wc !== 2 || wd !== 32'hFFFF_FF08) begin n_fail++; $display("FAIL byte_write: cycle %0d data %h want 2 ffffff08", wc, wd); end
      n_tests++; if (dc !== 3 || nw !== 1) begin n_fail++; $display("FAIL byte_done: cycle %0d writes %0d want 3 1", dc, nw); end
      n_tests++; if (mem1[12] !== 32'hFFFF_FF08) begin n_fail++; $display("FAIL byte_mem: got %h want ffffff08", mem1[12]); end
      preload1(4'd13, 32'h1122_3344);
      obs1(32'h37, 32'h0000_0077, 2'd2, wc, wd, wa, dc, e, nw, nr);
      n_tests++; if (wd !== 32'h1122_3377 || wa !== 32'h37) begin n_fail++; $display("FAIL byte_low_lane: data %h addr %h want 11223377 00000037", wd, wa); end
   endtask

   task automatic test_errors();
      logic [31:0] addrs [3];
      logic [1:0]  cts   [3];
      int wc, dc, nw, nr; logic [31:0] wd, wa; logic e;
      addrs[0] = 32'h40; cts[0] = 2'd3;
      addrs[1] = 32'h22; cts[1] = 2'd0;
      addrs[2] = 32'h21; cts[2] = 2'd1;
      preload1(4'd8, 32'h5555_5555);
      for (int i = 0; i < 3; i++) begin
         obs1(addrs[i], 32'hCAFE_F00D, cts[i], wc, wd, wa, dc, e, nw, nr);
         n_tests++;
         if (dc !== 1 || e !== 1'b1 || nw !== 0 || nr !== 0) begin
            n_fail++;
            $display("FAIL err_case%0d: done_cycle %0d err %b writes %0d reads %0d want 1 1 0 0", i, dc, e, nw, nr);
         end
      end
      n_tests++; if (mem1[8] !== 32'h5555_5555) begin n_fail++; $display("FAIL err_mem_untouched: got %h want 55555555", mem1[8]); end
   endtask

   task automatic test_lat3();
      int wc = -1, dc = -1, nw = 0, nr = 0; logic [31:0] wd = 32'd0;
      pl3_idx = 4'd8; pl3_val = 32'hFFFF_FFFF; pl3_en = 1'b1;
      tick();
      pl3_en = 1'b0;
      if3.addr = 32'h20; if3.data_b = 32'h0000_0008; if3.ct = 2'd1; if3.start = 1'b1;
      for (int c = 1; c <= 12; c++) begin
         tick();
         if (c == 1) begin if3.start = 1'b0; if3.data_b = 32'h0; end
         if (if3.mem_wr) begin nw++; wc = c; wd = if3.mem_wr_data; end
         else if (if3.busy && !if3.done) nr++;
         if (if3.done && dc < 0) dc = c;
      end
      n_tests++; if (nr !== 3) begin n_fail++; $display("FAIL lat3_reads: got %0d want 3", nr); end
      n_tests++; if (wc !== 4 || wd !== 32'hFFFF_0008 || nw !== 1) begin n_fail++; $display("FAIL lat3_write: cycle %0d data %h writes %0d want 4 ffff0008 1", wc, wd, nw); end
      n_tests++; if (dc !== 5) begin n_fail++; $display("FAIL lat3_done: got %0d want 5", dc); end
   endtask

   task automatic test_back_to_back();
      int nw = 0; int wcy [4]; logic [31:0] wdat [4]; logic [31:0] wadr [4];
      logic done3 = 1'b0, busy4 = 1'b1;
      for (int i = 0; i < 4; i++) begin wcy[i] = -1; wdat[i] = 32'd0; wadr[i] = 32'd0; end
      preload1(4'd8, 32'hFFFF_FFFF);
      if1.addr = 32'h20; if1.data_b = 32'h0000_0008; if1.ct = 2'd1; if1.start = 1'b1;
      for (int c = 1; c <= 10; c++) begin
         tick();
         if (if1.mem_wr && nw < 4) begin wcy[nw] = c; wdat[nw] = if1.mem_wr_data; wadr[nw] = if1.mem_addr; nw++; end
         if (c == 3) done3 = if1.done;
         if (c == 4) busy4 = if1.busy;
         case (c)
            1: begin if1.start = 1'b1; if1.addr = 32'h30; if1.data_b = 32'h99; if1.ct = 2'd0; end
            2: if1.start = 1'b0;
            3: if1.start = 1'b1;
            4: if1.start = 1'b1;
            default: if1.start = 1'b0;
         endcase
      end
      n_tests++; if (nw !== 2) begin n_fail++; $display("FAIL b2b_write_count: got %0d want 2", nw); end
      n_tests++; if (wcy[0] !== 2 || wadr[0] !== 32'h20 || wdat[0] !== 32'hFFFF_0008) begin n_fail++; $display("FAIL b2b_first: cycle %0d addr %h data %h want 2 00000020 ffff0008", wcy[0], wadr[0], wdat[0]); end
      n_tests++; if (done3 !== 1'b1 || busy4 !== 1'b0) begin n_fail++; $display("FAIL b2b_done_idle: done %b busy %b want 1 0", done3, busy4); end
      n_tests++; if (wcy[1] !== 5 || wadr[1] !== 32'h30 || wdat[1] !== 32'h99) begin n_fail++; $display("FAIL b2b_second: cycle %0d addr %h data %h want 5 00000030 00000099", wcy[1], wadr[1], wdat[1]); end
   endtask

   task automatic test_reset_mid();
      int nw = 0; int wc, dc, nw2, nr; logic [31:0] wd, wa; logic e;
      preload1(4'd8, 32'hFFFF_FFFF);
      if1.addr = 32'h20; if1.data_b = 32'h0000_1234; if1.ct = 2'd1; if1.start = 1'b1;
      tick();
      if1.start = 1'b0;
      n_tests++; if (if1.busy !== 1'b1) begin n_fail++; $display("FAIL rstmid_in_read: busy %b want 1", if1.busy); end
      reset = 1'b0;
      tick();
      reset = 1'b1;
      n_tests++; if (if1.busy !== 1'b0 || if1.mem_wr !== 1'b0 || if1.done !== 1'b0) begin n_fail++; $display("FAIL rstmid_abort: busy %b mem_wr %b done %b want 0 0 0", if1.busy, if1.mem_wr, if1.done); end
      for (int c = 0; c < 4; c++) begin tick(); if (if1.mem_wr) nw++; end
      n_tests++; if (nw !== 0 || mem1[8] !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL rstmid_no_write: writes %0d mem %h want 0 ffffffff", nw, mem1[8]); end
      obs1(32'h10, 32'h0000_0055, 2'd0, wc, wd, wa, dc, e, nw2, nr);
      n_tests++; if (wc !== 1 || wd !== 32'h55 || dc !== 2 || e !== 1'b0) begin n_fail++; $display("FAIL rstmid_recover: wr_cycle %0d data %h done %0d err %b want 1 00000055 2 0", wc, wd, dc, e); end
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      test_reset();
      test_word();
      test_halfword();
      test_byte();
      test_errors();
      test_lat3();
      test_back_to_back();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
